// File: rtl/riscv_pkg.sv
// Shared ISA encodings, ALU operation set and write-back selection for the riscv_core hierarchy.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_t;

  // alt selects SUB/SRA; callers only raise it where funct7 is meaningful
  function automatic alu_op_t alu_op_of(logic [2:0] f3, logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_core_if.sv
// Data-memory bus between the core datapath (master) and the data RAM (slave).
interface riscv_core_if;
  logic        we;
  logic [29:0] word_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, word_addr, wdata, input rdata);
  modport slave  (input we, word_addr, wdata, output rdata);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts use the low 5 bits of b, arithmetic wraps.
module alu
  import riscv_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/dmem.sv
// Word-addressed data RAM: combinational read, synchronous write, contents survive reset.
module dmem #(
  parameter int DMEM_WORDS = 64
) (
  input logic         clk,
  riscv_core_if.slave bus
);

  localparam int IW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0]   mem [0:DMEM_WORDS-1];
  logic [IW-1:0] idx;

  assign idx       = IW'(bus.word_addr % 30'(DMEM_WORDS));
  assign bus.rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (bus.we) mem[idx] <= bus.wdata;
  end

endmodule

// File: rtl/imem.sv
// Byte-wide instruction ROM, little-endian word fetch; fetches past the last byte return a NOP.
module imem
  import riscv_pkg::*;
#(
  parameter  int PROG_SIZE = 7,
  localparam int AW        = $clog2(PROG_SIZE + 1)
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [31:0]   addr,
  output logic [31:0]   instr
);

  logic [7:0]    tab_inst [0:PROG_SIZE];
  logic [AW-1:0] base;

  assign base = addr[AW-1:0];

  // Optional program-load port; reset never touches the contents
  always_ff @(posedge clk) begin
    if (load_en) tab_inst[load_addr] <= load_data;
  end

  always_comb begin
    instr = NOP_INSTR;
    if (addr <= 32'(PROG_SIZE - 3)) begin
      instr = {tab_inst[base + AW'(3)], tab_inst[base + AW'(2)],
               tab_inst[base + AW'(1)], tab_inst[base]};
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational reads, one synchronous write, x0 hard-wired to zero.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  // x0 is cleared on reset and never written, so a plain array read returns 0 for it
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I-subset core: decode, immediates and next-pc live here; every instruction retires on one edge.
module riscv_core
  import riscv_pkg::*;
#(
  parameter int PROG_SIZE  = 7,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst
);

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res, wb_data, mem_rdata;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        rf_we, mem_we, br_taken;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  riscv_core_if dbus ();

  imem #(.PROG_SIZE(PROG_SIZE)) imem1 (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (8'h00),
    .addr      (pc),
    .instr     (instr)
  );

  regfile rf1 (
    .clk    (clk),
    .rst_n  (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (wb_data)
  );

  dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem1 (
    .clk (clk),
    .bus (dbus.slave)
  );

  alu alu1 (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_res)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;

  assign dbus.we        = mem_we;
  assign dbus.word_addr = alu_res[31:2];
  assign dbus.wdata     = rs2_val;
  assign mem_rdata      = dbus.rdata;

  // Unsupported branch funct3 codes leave br_taken low, which is the NOP behaviour
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_val;
    alu_b   = imm_i;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = WB_ALU;
    pc_next = pc_plus4;
    case (opcode)
      OPC_OP: begin
        alu_b = rs2_val;
        if (funct7 == F7_BASE) begin
          rf_we  = 1'b1;
          alu_op = alu_op_of(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          rf_we  = 1'b1;
          alu_op = alu_op_of(funct3, 1'b1);
        end
      end
      OPC_OPIMM: begin
        alu_op = alu_op_of(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
        if (funct3 == F3_SLL)     rf_we = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) rf_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      rf_we = 1'b1;
      end
      OPC_LUI: begin
        alu_a = '0;
        alu_b = imm_u;
        rf_we = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
        rf_we = 1'b1;
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        alu_b  = imm_s;
        mem_we = (funct3 == F3_WORD);
      end
      OPC_BRANCH: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      OPC_JAL: begin
        rf_we   = 1'b1;
        wb_sel  = WB_PC4;
        pc_next = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == F3_JALR) begin
          rf_we   = 1'b1;
          wb_sel  = WB_PC4;
          // bit 1 is cleared as well so the fetch address stays word aligned
          pc_next = alu_res & ~32'h3;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next;
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed scoreboard bench for riscv_core: programs are poked into the ROM, expectations queued, then checked.
module tb_riscv_core;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [31:0] T_NOP   = 32'h0000_0013;

  localparam int K_REG_S = 0, K_PC_S = 1, K_REG_L = 2, K_PC_L = 3, K_MEM_L = 4;
  localparam int K_WE = 5, K_WADDR = 6, K_WDATA = 7, K_RDATA = 8;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_s;
  logic        rst_l;
  exp_t        sb [$];
  logic [31:0] prog [$];
  int          tests;
  int          fails;

  riscv_core #(.PROG_SIZE(7)) dut_s (.clk(clk), .rst(rst_s));
  riscv_core #(.PROG_SIZE(63), .DMEM_WORDS(64)) dut_l (.clk(clk), .rst(rst_l));

  riscv_core_if probe ();
  assign probe.we        = dut_l.mem_we;
  assign probe.word_addr = dut_l.alu_res[31:2];
  assign probe.wdata     = dut_l.rs2_val;
  assign probe.rdata     = dut_l.mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), T_OP};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], T_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3, int rs1, int rs2, int imm);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], T_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), T_JAL};
  endfunction

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      K_REG_S: return dut_s.rf1.regs[5'(idx)];
      K_PC_S:  return dut_s.pc;
      K_REG_L: return dut_l.rf1.regs[5'(idx)];
      K_PC_L:  return dut_l.pc;
      K_MEM_L: return dut_l.dmem1.mem[6'(idx)];
      K_WE:    return {31'b0, probe.we};
      K_WADDR: return {2'b0, probe.word_addr};
      K_WDATA: return probe.wdata;
      default: return probe.rdata;
    endcase
  endfunction

  task automatic push(string tag, int kind, int idx, logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.idx);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic load_s();
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      w = (i < prog.size()) ? prog[i] : T_NOP;
      for (int b = 0; b < 4; b++) dut_s.imem1.tab_inst[4*i+b] = w[8*b +: 8];
    end
    prog.delete();
  endtask

  task automatic load_l();
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (i < prog.size()) ? prog[i] : T_NOP;
      for (int b = 0; b < 4; b++) dut_l.imem1.tab_inst[4*i+b] = w[8*b +: 8];
    end
    prog.delete();
  endtask

  task automatic start_l();
    @(negedge clk);
    rst_l = 1'b0;
    load_l();
    #2;
    rst_l = 1'b1;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // x1=-1, x2=1; the branch at pc 8 targets pc 16, skipping addi x5,x0,7
  task automatic branch_case(string tag, logic [31:0] br, bit taken);
    prog.push_back(enc_i(-1, 0, 3'b000, 1, T_OPIMM));
    prog.push_back(enc_i(1, 0, 3'b000, 2, T_OPIMM));
    prog.push_back(br);
    prog.push_back(enc_i(7, 0, 3'b000, 5, T_OPIMM));
    prog.push_back(enc_i(1, 0, 3'b000, 6, T_OPIMM));
    push({tag, "_x5"}, K_REG_L, 5, taken ? 32'd0 : 32'd7);
    push({tag, "_pc"}, K_PC_L, 0, taken ? 32'd20 : 32'd16);
    start_l();
    step(4);
    check_all();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_s = 1'b0;
    rst_l = 1'b0;

    // Reset and end-of-program behaviour on the 2-instruction core
    prog.push_back(enc_i(1, 0, 3'b000, 1, T_OPIMM));
    prog.push_back(enc_i(2, 0, 3'b000, 2, T_OPIMM));
    load_s();
    #10;
    push("rst_pc", K_PC_S, 0, 32'd0);
    for (int i = 1; i < 32; i++) push($sformatf("rst_x%0d", i), K_REG_S, i, 32'd0);
    check_all();
    #11;
    rst_s = 1'b1;
    push("edge1_pc", K_PC_S, 0, 32'd4);
    push("edge1_x1", K_REG_S, 1, 32'd1);
    step(1);
    check_all();
    push("edge2_pc", K_PC_S, 0, 32'd8);
    push("edge2_x2", K_REG_S, 2, 32'd2);
    step(1);
    check_all();
    push("end_pc", K_PC_S, 0, 32'd40);
    push("end_x1", K_REG_S, 1, 32'd1);
    push("end_x2", K_REG_S, 2, 32'd2);
    push("end_x3", K_REG_S, 3, 32'd0);
    step(8);
    check_all();
    #2;
    rst_s = 1'b0;
    push("midrst_pc", K_PC_S, 0, 32'd0);
    push("midrst_x1", K_REG_S, 1, 32'd0);
    push("midrst_x2", K_REG_S, 2, 32'd0);
    #1;
    check_all();

    // Arithmetic
    prog.push_back(enc_i(5, 0, 3'b000, 1, T_OPIMM));
    prog.push_back(enc_i(-3, 0, 3'b000, 2, T_OPIMM));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b000, 3));
    prog.push_back(enc_r(7'h20, 1, 2, 3'b000, 4));
    push("arith_x1", K_REG_L, 1, 32'd5);
    push("arith_x2", K_REG_L, 2, 32'hFFFF_FFFD);
    push("arith_x3", K_REG_L, 3, 32'd2);
    push("arith_x4", K_REG_L, 4, 32'hFFFF_FFF8);
    push("arith_pc", K_PC_L, 0, 32'd16);
    start_l();
    step(4);
    check_all();

    // Branches, signed and unsigned
    branch_case("bge_x2_x1",  enc_b(3'b101, 2, 1, 8), 1'b1);
    branch_case("bge_x1_x2",  enc_b(3'b101, 1, 2, 8), 1'b0);
    branch_case("bge_x1_x1",  enc_b(3'b101, 1, 1, 8), 1'b1);
    branch_case("bgeu_x1_x2", enc_b(3'b111, 1, 2, 8), 1'b1);
    branch_case("blt_x1_x2",  enc_b(3'b100, 1, 2, 8), 1'b1);
    branch_case("bltu_x1_x2", enc_b(3'b110, 1, 2, 8), 1'b0);
    branch_case("beq_x1_x2",  enc_b(3'b000, 1, 2, 8), 1'b0);
    branch_case("bne_x1_x2",  enc_b(3'b001, 1, 2, 8), 1'b1);

    // Memory round trip and x0 write discard
    prog.push_back(enc_i(32'h55, 0, 3'b000, 1, T_OPIMM));
    prog.push_back(enc_s(8, 1, 0));
    prog.push_back(enc_i(8, 0, 3'b010, 6, T_LOAD));
    prog.push_back(enc_i(9, 0, 3'b000, 0, T_OPIMM));
    start_l();
    push("bus_we_idle", K_WE, 0, 32'd0);
    check_all();
    push("bus_we_sw", K_WE, 0, 32'd1);
    push("bus_addr_sw", K_WADDR, 0, 32'd2);
    push("bus_wdata_sw", K_WDATA, 0, 32'h55);
    step(1);
    check_all();
    push("bus_rdata_lw", K_RDATA, 0, 32'h55);
    push("bus_we_lw", K_WE, 0, 32'd0);
    step(1);
    check_all();
    push("mem_x6", K_REG_L, 6, 32'h55);
    push("mem_x0", K_REG_L, 0, 32'd0);
    push("mem_word2", K_MEM_L, 2, 32'h55);
    push("mem_pc", K_PC_L, 0, 32'd16);
    step(2);
    check_all();

    // Upper immediates, jumps and shifts/compares
    prog.push_back(enc_u(32'h12345, 7, T_LUI));
    prog.push_back(enc_u(1, 8, T_AUIPC));
    prog.push_back(enc_j(8, 9));
    prog.push_back(enc_i(1, 0, 3'b000, 10, T_OPIMM));
    prog.push_back(enc_i(35, 0, 3'b000, 12, T_OPIMM));
    prog.push_back(enc_i(0, 12, 3'b000, 11, T_JALR));
    prog.push_back(enc_i(2, 0, 3'b000, 10, T_OPIMM));
    prog.push_back(enc_i(3, 0, 3'b000, 10, T_OPIMM));
    prog.push_back(enc_i(-8, 0, 3'b000, 14, T_OPIMM));
    prog.push_back(enc_i(32'h401, 14, 3'b101, 15, T_OPIMM));
    prog.push_back(enc_i(28, 14, 3'b101, 16, T_OPIMM));
    prog.push_back(enc_r(7'h00, 14, 0, 3'b011, 17));
    prog.push_back(enc_r(7'h00, 0, 14, 3'b010, 18));
    prog.push_back(enc_i(-1, 14, 3'b100, 19, T_OPIMM));
    push("lui_x7", K_REG_L, 7, 32'h1234_5000);
    push("auipc_x8", K_REG_L, 8, 32'h0000_1004);
    push("jal_x9", K_REG_L, 9, 32'd12);
    push("skip_x10", K_REG_L, 10, 32'd0);
    push("jalr_x11", K_REG_L, 11, 32'd24);
    push("srai_x15", K_REG_L, 15, 32'hFFFF_FFFC);
    push("srli_x16", K_REG_L, 16, 32'h0000_000F);
    push("sltu_x17", K_REG_L, 17, 32'd1);
    push("slt_x18", K_REG_L, 18, 32'd1);
    push("xori_x19", K_REG_L, 19, 32'd7);
    push("misc_pc", K_PC_L, 0, 32'd56);
    start_l();
    step(11);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
